// File: rtl/sha256_id_issue.sv
// Issues sequential 6-bit packet IDs to the SHA-256 config synchroniser and
// tracks in-order returns against a credit limit, flagging bad returns.
module sha256_id_issue #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic       sync_rst,
  output logic [5:0] id_out,
  output logic       id_out_last,
  output logic       id_out_valid,
  input  logic       id_out_ready,
  input  logic [5:0] id_ret,
  input  logic       id_ret_valid,
  output logic       id_ret_ready,
  output logic [6:0] outstanding,
  output logic       id_err
);

  // Handshakes: a beat transfers on a rising edge where valid & ready are both
  // high; once raised, id_out_valid and id_out stay put until that transfer.
  localparam logic [6:0] MAX_CREDITS = 7'(MAX_OUTSTANDING);

  logic [5:0] exp_ret;
  logic       issue;
  logic       ret;
  logic       accepted_ret;
  logic [6:0] outstanding_nxt;
  logic       valid_nxt;

  assign id_ret_ready    = en;
  assign issue           = id_out_valid & id_out_ready;
  assign ret             = id_ret_valid & id_ret_ready;
  assign accepted_ret    = ret & (outstanding != 7'd0);
  assign outstanding_nxt = outstanding + {6'd0, issue} - {6'd0, accepted_ret};
  assign valid_nxt       = (id_out_valid & ~issue) | (en & (outstanding_nxt < MAX_CREDITS));

  // id_out doubles as the next-ID register: it only advances on an issue.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      id_out       <= 6'd0;
      id_out_last  <= 1'b0;
      id_out_valid <= 1'b0;
      outstanding  <= 7'd0;
      id_err       <= 1'b0;
      exp_ret      <= 6'd0;
    end else if (sync_rst) begin
      id_out       <= 6'd0;
      id_out_last  <= 1'b0;
      id_out_valid <= 1'b0;
      outstanding  <= 7'd0;
      id_err       <= 1'b0;
      exp_ret      <= 6'd0;
    end else begin
      outstanding  <= outstanding_nxt;
      id_out_valid <= valid_nxt;
      id_out_last  <= valid_nxt;
      if (issue) id_out <= id_out + 6'd1;
      // A mismatched return still consumes its slot so later IDs realign.
      if (accepted_ret) begin
        if (id_ret != exp_ret) id_err <= 1'b1;
        exp_ret <= exp_ret + 6'd1;
      end else if (ret) begin
        id_err <= 1'b1;
      end
    end
  end

endmodule
